regfile_wb_arbiter: RTL

Shares the single write port of the 32-entry register file between two writeback sources: port 0 (ALU result) and port 1 (load return). The block arbitrates round-robin with a valid/ready handshake per source and stages the winning write in one output register that drives the register file's write enable, address and data. It absorbs writes to x0 without using a port cycle, supports a synchronous flush, and can optionally forward the staged write to the two read ports.

---
 rtl/rv_pkg.sv | 10 +
 rtl/wb_rr_arb2.sv | 20 ++
 rtl/regfile_wb_arbiter.sv | 67 ++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: register-file widths and writeback source indices shared by the writeback path.
package rv_pkg;
   localparam int REG_WIDTH = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;
   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_LSU = 1'b1
   } wb_src_e;
endpackage

// File: rtl/wb_rr_arb2.sv
// wb_rr_arb2: two-request round-robin arbiter; the source not granted most recently wins contention.
module wb_rr_arb2
   import rv_pkg::*;
(
   input  logic       clock,
   input  logic       clear,
   input  logic       flush,
   input  logic [1:0] req,
   output logic [1:0] grant
);
   wb_src_e last;
   always_comb begin
      grant = 2'b00;
      if (!flush) grant = (req == 2'b11) ? ((last == WB_SRC_LSU) ? 2'b01 : 2'b10) : req;
   end
   always_ff @(posedge clock or posedge clear)
      if (clear) last <= WB_SRC_LSU;
      else if (grant[WB_SRC_ALU]) last <= WB_SRC_ALU;
      else if (grant[WB_SRC_LSU]) last <= WB_SRC_LSU;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU and load writeback.
// Define WB_BYPASS_EN to forward the staged write onto the two read operands.
module regfile_wb_arbiter
   import rv_pkg::*;
#(
   parameter int width = REG_WIDTH,
   parameter int addrWidth = REG_ADDR_WIDTH
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 flush,
   input  logic                 v0,
   input  logic                 v1,
   input  logic [addrWidth-1:0] rd0,
   input  logic [addrWidth-1:0] rd1,
   input  logic [width-1:0]     d0,
   input  logic [width-1:0]     d1,
   output logic                 rdy0,
   output logic                 rdy1,
   output logic                 regWriteEnable,
   output logic [addrWidth-1:0] addrD,
   output logic [width-1:0]     dataD
`ifdef WB_BYPASS_EN
   ,
   input  logic [addrWidth-1:0] addrA,
   input  logic [addrWidth-1:0] addrB,
   input  logic [width-1:0]     rfA,
   input  logic [width-1:0]     rfB,
   output logic [width-1:0]     opA,
   output logic [width-1:0]     opB
`endif
);
   logic [1:0] real_w, null_w, grant;
   always_comb begin
      real_w = {v1 && rd1 != addrWidth'(REG_ZERO), v0 && rd0 != addrWidth'(REG_ZERO)};
      null_w = {v1 && rd1 == addrWidth'(REG_ZERO), v0 && rd0 == addrWidth'(REG_ZERO)};
   end
   wb_rr_arb2 u_arb (
      .clock(clock),
      .clear(clear),
      .flush(flush),
      .req  (real_w),
      .grant(grant)
   );
   // x0 writes complete immediately and are simply dropped
   assign rdy0 = !flush && (null_w[WB_SRC_ALU] || grant[WB_SRC_ALU]);
   assign rdy1 = !flush && (null_w[WB_SRC_LSU] || grant[WB_SRC_LSU]);
   always_ff @(posedge clock or posedge clear)
      if (clear) begin
         regWriteEnable <= 1'b0;
         addrD          <= '0;
         dataD          <= '0;
      end else begin
         regWriteEnable <= |grant;
         if (grant[WB_SRC_ALU]) begin
            addrD <= rd0;
            dataD <= d0;
         end else if (grant[WB_SRC_LSU]) begin
            addrD <= rd1;
            dataD <= d1;
         end
      end
`ifdef WB_BYPASS_EN
   assign opA = (regWriteEnable && addrD == addrA) ? dataD : rfA;
   assign opB = (regWriteEnable && addrD == addrB) ? dataD : rfB;
`endif
endmodule
